byte_fetch_unit: RTL and testbench

BYTE_FETCH_UNIT -- requirements
Module: byte_fetch_unit

---
 rtl/byte_fetch_if.sv | 23 ++
 rtl/byte_fetch_unit.sv | 122 ++++++++++++
 tb/tb_byte_fetch_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/byte_fetch_if.sv
// Request/response and memory bus of the byte fetch unit.
// The slave modport is the fetch unit; the master modport is the core plus the byte memory.
interface byte_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [7:0]  address_out;
  logic [7:0]  data_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;

  modport slave (
    input  req_valid, req_addr, data_in, instr_ready,
    output req_ready, address_out, instr_valid, instr_out, pc_out
  );

  modport master (
    output req_valid, req_addr, data_in, instr_ready,
    input  req_ready, address_out, instr_valid, instr_out, pc_out
  );
endinterface

// File: rtl/byte_fetch_unit.sv
// Fetches four bytes from a byte-wide memory with one cycle of read latency.
// It assembles them into a 32-bit instruction word and holds the word until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// FETCH | issuing addresses and collecting bytes, cnt 0..4
// HOLD  | instruction word valid, waiting for instr_ready
module byte_fetch_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic              busy,
  byte_fetch_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [1:0]  lane;
  logic [4:0]  lsb;
  logic [7:0]  offs;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    valid_d = valid_q;
    lane    = cnt_q[1:0] - 2'd1;
    lsb     = BIG_ENDIAN ? (5'd24 - {lane, 3'b000}) : {lane, 3'b000};
    // Next address is base + min(cnt+1, 3): the last byte address repeats while its data returns.
    offs    = (cnt_q >= 3'd2) ? 8'd3 : {5'd0, cnt_q} + 8'd1;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            base_d  = {bus.req_addr[7:2], 2'b00};
            pc_d    = {bus.req_addr[7:2], 2'b00};
            addr_d  = {bus.req_addr[7:2], 2'b00};
            cnt_d   = 3'd0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (cnt_q != 3'd0) buf_d[lsb +: 8] = bus.data_in;
          if (cnt_q == 3'd4) begin
            instr_d = buf_d;
            valid_d = 1'b1;
            cnt_d   = 3'd0;
            state_d = HOLD;
          end else begin
            cnt_d  = cnt_q + 3'd1;
            addr_d = base_q + offs;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      base_q  <= 8'h00;
      addr_q  <= 8'h00;
      pc_q    <= 8'h00;
      buf_q   <= 32'h0;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.address_out = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_byte_fetch_unit.sv
// Directed bench for byte_fetch_unit: big- and little-endian instances share one stimulus stream,
// and each instance has its own byte memory returning addr ^ 0x5A one cycle late.
module tb_byte_fetch_unit;
  logic clk = 1'b0;
  logic rst, flush;
  logic busy, busy_le;
  int   checks = 0;
  int   errors = 0;

  byte_fetch_if bus ();
  byte_fetch_if bus_le ();

  byte_fetch_unit #(.BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rst(rst), .flush(flush), .busy(busy), .bus(bus));
  byte_fetch_unit #(.BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rst(rst), .flush(flush), .busy(busy_le), .bus(bus_le));

  assign bus_le.req_valid   = bus.req_valid;
  assign bus_le.req_addr    = bus.req_addr;
  assign bus_le.instr_ready = bus.instr_ready;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.data_in    <= bus.address_out ^ 8'h5A;
    bus_le.data_in <= bus_le.address_out ^ 8'h5A;
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = 8'h00; bus.instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    checks++; if (bus.address_out !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", bus.address_out); end
    checks++; if (bus.instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", bus.instr_out); end
    checks++; if (bus.pc_out !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", bus.pc_out); end
  endtask

  // Issue one request and follow it into HOLD, checking the address sequence and the assembled word.
  task automatic run_fetch(input logic [7:0] a, input logic [7:0] pc,
                           input logic [31:0] be, input logic [31:0] le);
    logic [7:0] ea;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready_%h got %b want 1", a, bus.req_ready); end
    bus.req_addr = a; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ea = pc + ((i < 3) ? 8'(i) : 8'd3);
      checks++; if (bus.address_out !== ea) begin errors++; $display("FAIL fetch_addr_%h[%0d] got %h want %h", a, i, bus.address_out, ea); end
      checks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_state_%h[%0d] got valid=%b busy=%b want valid=0 busy=1", a, i, bus.instr_valid, busy); end
      @(negedge clk);
    end
    checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_%h got %b want 1", a, bus.instr_valid); end
    checks++; if (bus.instr_out !== be) begin errors++; $display("FAIL word_be_%h got %h want %h", a, bus.instr_out, be); end
    checks++; if (bus_le.instr_out !== le) begin errors++; $display("FAIL word_le_%h got %h want %h", a, bus_le.instr_out, le); end
    checks++; if (bus.pc_out !== pc) begin errors++; $display("FAIL pc_%h got %h want %h", a, bus.pc_out, pc); end
  endtask

  task automatic release_hold(input logic [31:0] be);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL release got valid=%b ready=%b busy=%b want 0 1 0", bus.instr_valid, bus.req_ready, busy); end
    checks++; if (bus.instr_out !== be) begin errors++; $display("FAIL release_hold_word got %h want %h", bus.instr_out, be); end
  endtask

  task automatic test_basic_fetch();
    run_fetch(8'h12, 8'h10, 32'h4A4B4849, 32'h49484B4A);
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = i[0]; bus.req_addr = 8'h80;
      @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.instr_out !== 32'h4A4B4849 || bus.pc_out !== 8'h10) begin
        errors++; $display("FAIL stall[%0d] got valid=%b ready=%b word=%h pc=%h want 1 0 4a4b4849 10", i, bus.instr_valid, bus.req_ready, bus.instr_out, bus.pc_out);
      end
    end
    bus.req_valid = 1'b0;
    release_hold(32'h4A4B4849);
  endtask

  task automatic test_top_of_memory();
    run_fetch(8'hFF, 8'hFC, 32'hA6A7A4A5, 32'hA5A4A7A6);
    release_hold(32'hA6A7A4A5);
  endtask

  task automatic test_flush();
    bus.req_addr = 8'h31; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_state got busy=%b ready=%b valid=%b want 0 1 0", busy, bus.req_ready, bus.instr_valid); end
    checks++; if (bus.instr_out !== 32'hA6A7A4A5 || bus.pc_out !== 8'h30) begin errors++; $display("FAIL flush_hold got word=%h pc=%h want a6a7a4a5 30", bus.instr_out, bus.pc_out); end
    // A flush also outranks a request presented on the same edge.
    flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 8'h40;
    @(negedge clk);
    flush = 1'b0; bus.req_valid = 1'b0;
    checks++; if (busy !== 1'b0 || bus.pc_out !== 8'h30) begin errors++; $display("FAIL flush_prio got busy=%b pc=%h want 0 30", busy, bus.pc_out); end
    repeat (6) begin
      @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_no_valid got %b want 0", bus.instr_valid); end
    end
    run_fetch(8'h20, 8'h20, 32'h7A7B7879, 32'h79787B7A);
    release_hold(32'h7A7B7879);
  endtask

  task automatic test_back_to_back();
    run_fetch(8'h07, 8'h04, 32'h5E5F5C5D, 32'h5D5C5F5E);
    release_hold(32'h5E5F5C5D);
    run_fetch(8'h08, 8'h08, 32'h52535051, 32'h51505352);
    release_hold(32'h52535051);
  endtask

  task automatic test_reset_in_hold();
    run_fetch(8'h44, 8'h44, 32'h1E1F1C1D, 32'h1D1C1F1E);
    rst = 1'b1; flush = 1'b1; bus.req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; bus.req_valid = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_state got valid=%b busy=%b ready=%b want 0 0 1", bus.instr_valid, busy, bus.req_ready); end
    checks++; if (bus.address_out !== 8'h00 || bus.pc_out !== 8'h00 || bus.instr_out !== 32'h0) begin errors++; $display("FAIL rst_hold_outputs got addr=%h pc=%h word=%h want 00 00 00000000", bus.address_out, bus.pc_out, bus.instr_out); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_top_of_memory();
    test_flush();
    test_back_to_back();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
